// File: rtl/card_draw_rng_pkg.sv
// Shared definitions for the blackjack card generator: suit codes, deck sizes,
// draw FSM encoding and default LFSR configuration.
package bj_card_pkg;

    typedef enum logic [1:0] {
        SUIT_DIAMOND = 2'd0,
        SUIT_CLUB    = 2'd1,
        SUIT_HEART   = 2'd2,
        SUIT_SPADE   = 2'd3
    } suit_e;

    localparam int NUM_RANKS = 13;
    localparam int NUM_CARDS = 52;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_SCAN = 2'd2
    } draw_state_e;

    localparam logic [15:0] DEFAULT_TAPS = 16'hD008;
    localparam logic [15:0] DEFAULT_SEED = 16'h0002;

endpackage

// File: rtl/card_draw_rng_if.sv
// Bundle between the game FSM (master) and the card generator (slave),
// including debug visibility of the draw FSM state and the raw LFSR.
interface card_draw_rng_if #(
    parameter int LFSR_W = 16
);
    import bj_card_pkg::*;

    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic              shuffle;
    logic              draw_req;
    logic              busy;
    logic              card_valid;
    logic [3:0]        rank;
    logic [1:0]        suit;
    logic              draw_err;
    logic [5:0]        cards_left;
    logic              deck_empty;
    draw_state_e       dbg_state;
    logic [LFSR_W-1:0] dbg_lfsr;

    // draw_req is taken on a clock edge only while busy=0; each accepted request
    // ends in exactly one card_valid pulse unless aborted by shuffle or reset,
    // and a request against an empty deck ends in one draw_err pulse instead.
    modport master (
        output seed_load, seed, shuffle, draw_req,
        input  busy, card_valid, rank, suit, draw_err, cards_left, deck_empty,
        input  dbg_state, dbg_lfsr
    );

    modport slave (
        input  seed_load, seed, shuffle, draw_req,
        output busy, card_valid, rank, suit, draw_err, cards_left, deck_empty,
        output dbg_state, dbg_lfsr
    );

endinterface

// File: rtl/card_draw_rng_lfsr.sv
// Free-running Fibonacci LFSR with seed load; a zero load value is forced to 1
// so the register can never lock up in the all-zero state.
module lfsr_core
    import bj_card_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q, q_d;

    always_comb begin
        q_d = {q_q[LFSR_W-2:0], ^(q_q & TAPS)};
        if (load) begin
            q_d = (load_val == '0) ? LFSR_W'(1) : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_draw_rng.sv
// Uniform card generator: rejection-samples LFSR candidates, optionally tracks
// dealt cards so each card appears once per shuffle, with a linear-scan fallback.
module card_draw_rng
    import bj_card_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
    parameter bit                NO_REPEAT = 1'b1,
    parameter int                MAX_TRIES = 8
) (
    input logic            clk,
    input logic            rst,
    card_draw_rng_if.slave bus
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    logic [LFSR_W-1:0] lfsr;
    logic [5:0]        cand_idx;
    logic [5:0]        pick_idx;
    logic              pick_ok;
    logic              deck_empty;

    draw_state_e       state_q, state_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [5:0]        scan_q, scan_d;
    logic [63:0]       dealt_q, dealt_d;
    logic [5:0]        cards_left_q, cards_left_d;
    logic              card_valid_q, card_valid_d;
    logic              draw_err_q, draw_err_d;
    logic [3:0]        rank_q, rank_d;
    logic [1:0]        suit_q, suit_d;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.seed_load),
        .load_val (bus.seed),
        .q        (lfsr)
    );

    // Card index is {suit, rank-1}; nibble values 13..15 are never real cards.
    assign cand_idx   = {lfsr[1:0], lfsr[5:2]};
    assign pick_idx   = (state_q == ST_SCAN) ? scan_q : cand_idx;
    assign pick_ok    = (pick_idx[3:0] < 4'(NUM_RANKS)) && !(NO_REPEAT && dealt_q[pick_idx]);
    assign deck_empty = NO_REPEAT && (cards_left_q == 6'd0);

    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        scan_d       = scan_q;
        dealt_d      = dealt_q;
        cards_left_d = cards_left_q;
        card_valid_d = 1'b0;
        draw_err_d   = 1'b0;
        rank_d       = rank_q;
        suit_d       = suit_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.draw_req) begin
                    if (deck_empty) begin
                        draw_err_d = 1'b1;
                    end else begin
                        state_d = ST_DRAW;
                        tries_d = '0;
                    end
                end
            end
            ST_DRAW, ST_SCAN: begin
                if (pick_ok) begin
                    state_d      = ST_IDLE;
                    card_valid_d = 1'b1;
                    rank_d       = pick_idx[3:0] + 4'd1;
                    suit_d       = pick_idx[5:4];
                    if (NO_REPEAT) begin
                        dealt_d[pick_idx] = 1'b1;
                        cards_left_d      = cards_left_q - 6'd1;
                    end
                end else if (state_q == ST_SCAN) begin
                    scan_d = scan_q + 6'd1;
                end else if (NO_REPEAT && (tries_q == TRY_W'(MAX_TRIES - 1))) begin
                    state_d = ST_SCAN;
                    scan_d  = '0;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shuffle overrides everything above, including a same-cycle accept.
        if (bus.shuffle) begin
            state_d      = ST_IDLE;
            dealt_d      = '0;
            cards_left_d = 6'(NUM_CARDS);
            card_valid_d = 1'b0;
            draw_err_d   = 1'b0;
            rank_d       = rank_q;
            suit_d       = suit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tries_q      <= '0;
            scan_q       <= '0;
            dealt_q      <= '0;
            cards_left_q <= 6'(NUM_CARDS);
            card_valid_q <= 1'b0;
            draw_err_q   <= 1'b0;
            rank_q       <= '0;
            suit_q       <= '0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            scan_q       <= scan_d;
            dealt_q      <= dealt_d;
            cards_left_q <= cards_left_d;
            card_valid_q <= card_valid_d;
            draw_err_q   <= draw_err_d;
            rank_q       <= rank_d;
            suit_q       <= suit_d;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.card_valid = card_valid_q;
    assign bus.draw_err   = draw_err_q;
    assign bus.rank       = rank_q;
    assign bus.suit       = suit_q;
    assign bus.cards_left = cards_left_q;
    assign bus.deck_empty = deck_empty;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_lfsr   = lfsr;

endmodule

// File: doc/card_draw_rng.md
Name: card_draw_rng

Overview:
Parametrised card generator for the blackjack game logic. It draws uniformly distributed cards: rank 1..13 and suit 0..3 over all four suits. It uses a configurable Fibonacci LFSR with rejection sampling, a seed load, and an optional no-replacement deck mode. In that mode a dealt-card bitmap guarantees each of the 52 cards appears at most once per shuffle. It sits between the game FSM (draw requests) and the hand/score logic (card consumers).

Parameters:
LFSR_W, 16, LFSR width (min 8).
TAPS, 16'hD008, feedback tap mask (bits 15,14,12,3); feedback = XOR-reduce(lfsr & TAPS).
SEED, 16'h0002, LFSR reset value; must be nonzero.
NO_REPEAT, 1, 1 = draw without replacement (deck mode), 0 = infinite shoe.
MAX_TRIES, 8, rejected candidates before falling back to linear scan (deck mode only).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
seed_load  in  1  load seed into LFSR this cycle
seed  in  LFSR_W  seed value; 0 is replaced by 1
shuffle  in  1  clear dealt bitmap, abort any draw in progress
draw_req  in  1  request one card; sampled only when busy=0
busy  out  1  draw in progress
card_valid  out  1  one-cycle pulse, rank/suit valid
rank  out  4  1..13 (1=A, 11=J, 12=Q, 13=K), held until next card_valid
suit  out  2  0 diamond, 1 club, 2 heart, 3 spade, held
draw_err  out  1  one-cycle pulse: draw_req while deck empty
cards_left  out  6  undealt cards, 52..0 (fixed 52 when NO_REPEAT=0)
deck_empty  out  1  cards_left==0 (always 0 when NO_REPEAT=0)

Behaviour:
- Reset: lfsr=SEED, dealt bitmap=0, state IDLE, busy=0, card_valid=0, draw_err=0, rank=0, suit=0, cards_left=52, deck_empty=0.
- LFSR free-runs every cycle: lfsr <= {lfsr[W-2:0], fb}. seed_load overrides the step (lfsr <= seed, or 1 if seed==0).
- Candidate each cycle: suit_c=lfsr[1:0], nib=lfsr[5:2]; idx={suit_c,nib}. Reject if nib>=13. In deck mode also reject if dealt[idx].
- FSM states IDLE, DRAW, SCAN.
  - IDLE: draw_req && !deck_empty -> DRAW, busy=1, try counter=0.
  - IDLE: draw_req && deck_empty -> draw_err pulse next cycle, stay IDLE.
  - DRAW: each cycle evaluate the candidate. On accept -> IDLE; next cycle card_valid=1, rank=nib+1, suit=suit_c; in deck mode set dealt[idx] and decrement cards_left.
  - DRAW: on reject, increment tries; tries==MAX_TRIES-1 reject -> SCAN with scan pointer=0. NO_REPEAT=0 never enters SCAN.
  - SCAN: one index per cycle, 0..63. Skip nib>=13 and dealt entries. The first valid index is accepted exactly as in DRAW.
  - SCAN: pointer wraps 63->0. The deck is non-empty, so SCAN terminates within 64 cycles.
- Latency: minimum 2 cycles from draw_req sampled to card_valid. Worst case (deck mode) MAX_TRIES+64+1 cycles.
- busy falls in the same cycle card_valid rises; draw_req may be asserted then and is accepted.
- shuffle (any state): dealt=0, cards_left=52, state->IDLE, busy=0. A pending draw is aborted with no card_valid. shuffle wins over a same-cycle accept and over a same-cycle draw_req.
- seed_load concurrent with shuffle or a draw: both take effect; the candidate in that cycle uses the pre-load lfsr.
- Reset mid-draw: all reset values; no card_valid.
- The last card (cards_left 1->0) sets deck_empty on the same edge as card_valid.

Decomposition:
- Package bj_card_pkg:
  - suit codes SUIT_DIAMOND..SUIT_SPADE
  - NUM_RANKS=13, NUM_CARDS=52
  - FSM state encoding
  - default TAPS/SEED
- Sub-module lfsr_core (LFSR_W, TAPS, SEED; ports clk, rst, load, load_val, q): free-running shift register with zero-seed guard. Rejection, bitmap and FSM stay in card_draw_rng.

Test Plan:
- Reset, then 16 cycles idle with SEED=16'h0002 -> lfsr progresses 0x0002,0x0004,0x0008,...; all outputs at reset values, cards_left=52.
- NO_REPEAT=1, 52 back-to-back draws -> 52 card_valid pulses, all {rank,suit} distinct, rank in 1..13, cards_left decrements to 0, deck_empty=1; 53rd draw_req -> draw_err pulse, no card_valid.
- seed_load 16'hACE1, 10 draws, shuffle, seed_load 16'hACE1, 10 draws with identical request timing -> identical card sequences.
- seed_load with seed=0 -> lfsr=0x0001, generation continues (never locks at zero).
- MAX_TRIES=1, deal 51 cards, draw last -> enters SCAN, card_valid within 66 cycles, card is the single undealt one.
- shuffle asserted while busy=1 -> busy=0 next cycle, no card_valid, cards_left=52; following draw succeeds.
